event_timer_sched: RTL and testbench
====================================

EVENT_TIMER_SCHED -- requirements
Module: event_timer_sched

Interface
REQ-001 Parameter CLK_FREQ, default 16_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, shared tick rate in Hz; DIV = CLK_FREQ / TICK_HZ, integer division, DIV >= 2.
REQ-003 Parameter CNT_W, default 16, width of each channel period/remaining counter.
REQ-004 clk  input  1  system clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  high: prescaler and channels advance; low: all counters hold.
REQ-007 start  input  4  per-channel start/restart request, sampled every cycle.
REQ-008 stop  input  4  per-channel stop request, sampled every cycle.
REQ-009 periodic  input  4  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-010 period  input  4*CNT_W  per-channel period in ticks; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 tick  output  1  one-cycle pulse at TICK_HZ, shared timebase.
REQ-012 busy  output  4  per-channel: high while the channel is in RUN.
REQ-013 expired  output  4  per-channel one-cycle expiry pulse.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 while enable is high, wrap to 0 after DIV-1, and hold when enable is low.
REQ-015 tick SHALL be registered, asserting for exactly one cycle in the cycle after the prescaler is at DIV-1 with enable high; tick period = DIV cycles.
REQ-016 Each channel SHALL implement states IDLE and RUN, with a CNT_W-bit remaining counter, a latched period, and a latched mode bit.
REQ-017 Request priority per channel: stop > start > tick.
REQ-018 stop in any state SHALL go to IDLE next cycle with no expired pulse, even when coinciding with an expiring tick.
REQ-019 start with period != 0 and no stop (from IDLE or RUN) SHALL latch period and periodic, load remaining = period, and enter RUN; a coinciding tick is ignored for that channel.
REQ-020 start with period == 0 SHALL pulse expired next cycle and leave the channel in IDLE, regardless of mode.
REQ-021 In RUN, on a tick cycle with no start/stop: if remaining > 1, decrement by 1.
REQ-022 In RUN, on a tick cycle with remaining == 1: pulse expired next cycle; periodic SHALL reload the latched period and stay in RUN; one-shot SHALL enter IDLE.
REQ-023 A period-N channel started at tick-aligned time SHALL expire on the Nth subsequent tick; periodic expiries SHALL recur every N ticks with no drift.
REQ-024 Changes to period and periodic inputs while in RUN SHALL have no effect until the next start.
REQ-025 While enable is low, channels SHALL still honour start and stop; no tick-driven decrement occurs.
REQ-026 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL all pulse in the same cycle.
REQ-027 busy SHALL be registered and reflect state: high in RUN, low in IDLE.

Reset
REQ-028 While rst is high: prescaler = 0, tick = 0, all channels IDLE, remaining = 0, busy = 0, expired = 0; start/stop ignored.
REQ-029 rst asserted mid-run SHALL abort all channels without expired pulses; the first tick after release SHALL occur DIV cycles after the first enabled cycle.

Verification (sim with CLK_FREQ=16, TICK_HZ=1, DIV=16)
REQ-030 enable=1 constant after reset -> tick pulses one cycle wide, exactly every 16 cycles.
REQ-031 ch0 one-shot, period=3, start pulsed -> busy[0] high next cycle; expired[0] single pulse after the 3rd tick; busy[0] low afterwards.
REQ-032 ch1 periodic, period=2 -> expired[1] every 32 cycles across 4 expiries; period changed to 5 mid-run has no effect.
REQ-033 ch2 stop asserted in the cycle of its expiring tick -> no expired[2]; busy[2] low next cycle.
REQ-034 start on ch3 with period=0 -> expired[3] single pulse next cycle, busy[3] stays low; restart of ch0 mid-run -> remaining reloaded, expiry moves later.
REQ-035 enable low for 40 cycles mid-run -> no ticks, remaining unchanged; rst mid-run -> all busy low, no expired pulse.

Source files
------------

// File: rtl/event_timer_sched.sv
// event_timer_sched: shared prescaler producing a TICK_HZ timebase plus four
// independent event channels that count down in ticks and pulse on expiry.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   enable    high: prescaler and channels advance; low: counters hold
//   start     per-channel start/restart request
//   stop      per-channel stop request (wins over start and tick)
//   periodic  per-channel mode latched at start (1 = auto-reload)
//   period    per-channel period in ticks, channel i at [i*CNT_W +: CNT_W]
//   tick      one-cycle pulse every DIV cycles
//   busy      per-channel, high while in RUN
//   expired   per-channel one-cycle expiry pulse
module event_timer_sched #(
  parameter int unsigned CLK_FREQ = 16_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3:0]         start,
  input  logic [3:0]         stop,
  input  logic [3:0]         periodic,
  input  logic [4*CNT_W-1:0] period,
  output logic               tick,
  output logic [3:0]         busy,
  output logic [3:0]         expired
);

  // DIV must be at least 2 for the prescaler to make sense.
  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PrescMax = PW'(DIV - 1);
  localparam logic [PW-1:0]    PrescOne = PW'(1);
  localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);

  typedef enum logic {StIdle, StRun} state_e;

  // Prescaler and tick
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PrescOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // Channels
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CNT_W-1:0] rem_q   [4];
  logic [CNT_W-1:0] rem_d   [4];
  logic [CNT_W-1:0] per_q   [4];
  logic [CNT_W-1:0] per_d   [4];
  logic [3:0]       mode_q, mode_d;
  logic [3:0]       exp_q, exp_d;

  // A tick pulse that lands while enable has dropped must not decrement.
  logic ch_tick;
  assign ch_tick = tick_q & enable;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    per_d   = per_q;
    mode_d  = mode_q;
    exp_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (stop[i]) begin
        state_d[i] = StIdle;
        rem_d[i]   = '0;
      end else if (start[i]) begin
        if (period[i*CNT_W +: CNT_W] == '0) begin
          // Zero period expires immediately and never runs.
          state_d[i] = StIdle;
          rem_d[i]   = '0;
          exp_d[i]   = 1'b1;
        end else begin
          state_d[i] = StRun;
          rem_d[i]   = period[i*CNT_W +: CNT_W];
          per_d[i]   = period[i*CNT_W +: CNT_W];
          mode_d[i]  = periodic[i];
        end
      end else if (state_q[i] == StRun && ch_tick) begin
        if (rem_q[i] > RemOne) begin
          rem_d[i] = rem_q[i] - RemOne;
        end else begin
          exp_d[i] = 1'b1;
          if (mode_q[i]) begin
            rem_d[i] = per_q[i];
          end else begin
            state_d[i] = StIdle;
            rem_d[i]   = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        rem_q[i]   <= '0;
        per_q[i]   <= '0;
      end
      mode_q <= '0;
      exp_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        per_q[i]   <= per_d[i];
      end
      mode_q <= mode_d;
      exp_q  <= exp_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (state_q[i] == StRun);
    end
  end

  assign expired = exp_q;

endmodule

// File: tb/tb_event_timer_sched.sv
// Bench for event_timer_sched with DIV = 16. Expected expiry cycles are
// computed from the tick arithmetic and queued; a negedge monitor matches
// every expired pulse against the queue and flags unexpected pulses.
module tb_event_timer_sched;

  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [3:0]         start;
  logic [3:0]         stop;
  logic [3:0]         periodic;
  logic [4*CNT_W-1:0] period;
  logic               tick;
  logic [3:0]         busy;
  logic [3:0]         expired;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;
  exp_t sb[$];

  event_timer_sched #(
    .CLK_FREQ(16),
    .TICK_HZ (1),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .period  (period),
    .tick    (tick),
    .busy    (busy),
    .expired (expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [3:0] m);
    foreach (sb[k]) begin
      if (sb[k].cyc == c) begin
        sb[k].mask = sb[k].mask | m;
        return;
      end
    end
    sb.push_back('{cyc: c, mask: m});
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    logic [3:0] want;
    logic       hit;
    want = '0;
    hit  = 1'b0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        want = sb[k].mask;
        hit  = 1'b1;
        sb.delete(k);
      end else if (sb[k].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_stale: cycle %0d entry %0d mask %b never matched", cyc, sb[k].cyc,
                 sb[k].mask);
        sb.delete(k);
      end
    end
    if (hit) begin
      checks++;
      if (expired !== want) begin
        errors++;
        $display("FAIL expired@%0d: got %b want %b", cyc, expired, want);
      end
    end else if (expired !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_expired@%0d: got %b want 0000", cyc, expired);
    end
  end

  task automatic wait_tick(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout@%0d: got %b want 1", cyc, tick);
    end
    t = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    @(negedge clk);
    start = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; start = '0; stop = '0; periodic = '0; period = '0;
    repeat (2) @(negedge clk);
    period[0 +: CNT_W] = 16'd3;
    start = 4'hF;
    repeat (2) @(negedge clk);
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++;
    if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
    checks++;
    if (expired !== 4'b0) begin
      errors++; $display("FAIL reset_expired: got %b want 0000", expired);
    end
    start = '0;
  endtask

  task automatic test_tick();
    int c0, t, tp;
    enable = 1'b1;
    rst = 1'b0;
    c0 = cyc;
    wait_tick(t);
    checks++;
    if (t !== c0 + 16) begin
      errors++; $display("FAIL first_tick: got cycle %0d want %0d", t, c0 + 16);
    end
    @(negedge clk);
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %b want 0", tick); end
    for (int i = 0; i < 3; i++) begin
      tp = t;
      wait_tick(t);
      checks++;
      if (t - tp !== 16) begin
        errors++; $display("FAIL tick_period: got %0d want 16", t - tp);
      end
    end
  endtask

  task automatic test_oneshot();
    int t;
    wait_tick(t);
    period[0 +: CNT_W] = 16'd3;
    periodic[0] = 1'b0;
    push(t + 49, 4'b0001);
    pulse_start(4'b0001);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL oneshot_busy: got %b want 1", busy[0]); end
    wait_until(t + 48);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL oneshot_busy_late: got %b want 1", busy[0]); end
    wait_until(t + 50);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL oneshot_idle: got %b want 0", busy[0]); end
  endtask

  task automatic test_periodic();
    int t;
    wait_tick(t);
    period[CNT_W +: CNT_W] = 16'd2;
    periodic[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(t + 33 + 32 * k, 4'b0010);
    pulse_start(4'b0010);
    period[CNT_W +: CNT_W] = 16'd5;
    periodic[1] = 1'b0;
    wait_until(t + 100);
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL periodic_busy: got %b want 1", busy[1]); end
    wait_until(t + 130);
    stop = 4'b0010;
    @(negedge clk);
    stop = '0;
    checks++;
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL periodic_stop: got %b want 0", busy[1]); end
  endtask

  task automatic test_stop_on_expiry();
    int t;
    wait_tick(t);
    period[2*CNT_W +: CNT_W] = 16'd2;
    periodic[2] = 1'b0;
    pulse_start(4'b0100);
    wait_until(t + 32);
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL stop_tick_align: got %b want 1", tick); end
    checks++;
    if (busy[2] !== 1'b1) begin errors++; $display("FAIL stop_busy_pre: got %b want 1", busy[2]); end
    stop = 4'b0100;
    @(negedge clk);
    stop = '0;
    checks++;
    if (busy[2] !== 1'b0) begin errors++; $display("FAIL stop_busy_post: got %b want 0", busy[2]); end
  endtask

  task automatic test_zero_period();
    @(negedge clk);
    period[3*CNT_W +: CNT_W] = '0;
    periodic[3] = 1'b1;
    push(cyc + 1, 4'b1000);
    pulse_start(4'b1000);
    checks++;
    if (busy[3] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy[3]); end
    @(negedge clk);
    checks++;
    if (busy[3] !== 1'b0) begin errors++; $display("FAIL zero_busy_2: got %b want 0", busy[3]); end
  endtask

  task automatic test_restart();
    int t;
    wait_tick(t);
    period[0 +: CNT_W] = 16'd3;
    periodic[0] = 1'b0;
    pulse_start(4'b0001);
    wait_until(t + 20);
    push(t + 65, 4'b0001);
    pulse_start(4'b0001);
    wait_until(t + 50);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy[0]); end
    wait_until(t + 66);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b want 0", busy[0]); end
  endtask

  task automatic test_enable_hold();
    int t, t2;
    int seen = 0;
    wait_tick(t);
    period[0 +: CNT_W] = 16'd2;
    periodic[0] = 1'b0;
    push(t + 73, 4'b0001);
    pulse_start(4'b0001);
    wait_until(t + 20);
    enable = 1'b0;
    repeat (39) begin
      @(negedge clk);
      if (tick !== 1'b0) seen++;
    end
    @(negedge clk);
    enable = 1'b1;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL hold_ticks: got %0d want 0", seen); end
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", busy[0]); end
    wait_tick(t2);
    checks++;
    if (t2 !== t + 72) begin
      errors++; $display("FAIL hold_resume_tick: got cycle %0d want %0d", t2, t + 72);
    end
    wait_until(t + 75);
  endtask

  task automatic test_simultaneous();
    int t;
    wait_tick(t);
    period[0 +: CNT_W] = 16'd1;
    period[CNT_W +: CNT_W] = 16'd1;
    periodic[1:0] = 2'b00;
    push(t + 17, 4'b0011);
    pulse_start(4'b0011);
    wait_until(t + 18);
    checks++;
    if (busy[1:0] !== 2'b00) begin errors++; $display("FAIL simul_idle: got %b want 00", busy[1:0]); end
  endtask

  task automatic test_reset_midrun();
    int t, c0, t2;
    wait_tick(t);
    period[0 +: CNT_W] = 16'd3;
    period[CNT_W +: CNT_W] = 16'd2;
    periodic[1:0] = 2'b10;
    pulse_start(4'b0011);
    wait_until(t + 20);
    rst = 1'b1;
    @(negedge clk);
    start = 4'b0001;
    checks++;
    if (busy !== 4'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0000", busy); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 4'b0) begin errors++; $display("FAIL midrst_start_ignored: got %b want 0000", busy); end
    start = '0;
    rst = 1'b0;
    c0 = cyc;
    wait_tick(t2);
    checks++;
    if (t2 !== c0 + 16) begin
      errors++; $display("FAIL midrst_first_tick: got cycle %0d want %0d", t2, c0 + 16);
    end
    wait_until(t + 90);
    checks++;
    if (busy !== 4'b0) begin errors++; $display("FAIL midrst_busy_end: got %b want 0000", busy); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_oneshot();
    test_periodic();
    test_stop_on_expiry();
    test_zero_period();
    test_restart();
    test_enable_hold();
    test_simultaneous();
    test_reset_midrun();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
